// File: rtl/sdram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arbiter_pkg
//   Shared definitions for the SDRAM requester arbiter: default port count and
//   bus widths, the fixed requester slot indices and the arbiter state enum.
//   A small helper maps a round-robin offset onto the bulk requester slots.
// ---------------------------------------------------------------------------
package sdram_arbiter_pkg;

  // Default geometry.
  localparam int NREQ = 5;
  localparam int AW   = 23;
  localparam int DW   = 32;

  // Requester slots. Play and record are real-time; the rest are bulk.
  localparam int REQ_PLAY  = 0;
  localparam int REQ_REC   = 1;
  localparam int REQ_MIX   = 2;
  localparam int REQ_PITCH = 3;
  localparam int REQ_LOAD  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Bulk slot visited at offset k when the scan starts at ptr. Bulk slots
  // occupy REQ_MIX..nreq-1 and the scan wraps back to REQ_MIX.
  function automatic int bulk_index(input int ptr, input int k, input int nreq);
    int idx;
    idx = ptr + k;
    if (idx >= nreq) idx = idx - (nreq - REQ_MIX);
    return idx;
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// ---------------------------------------------------------------------------
// sdram_arb_pick
//   Combinational winner selection. Play beats record, record beats every
//   bulk requester; among the bulk slots the scan starts at ptr and wraps, so
//   a pointer fixed at REQ_MIX gives plain fixed priority.
//
//   Ports
//     pending  in  NREQ  requesters currently asking (read or write)
//     ptr      in  IW    first bulk slot to consider
//     valid    out 1     some requester is pending
//     winner   out IW    index of the selected requester
// ---------------------------------------------------------------------------
module sdram_arb_pick #(
  parameter int NREQ = sdram_arbiter_pkg::NREQ,
  parameter int IW   = $clog2(sdram_arbiter_pkg::NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   winner
);
  import sdram_arbiter_pkg::*;

  localparam int NBULK = NREQ - REQ_MIX;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    if (pending[REQ_PLAY]) begin
      valid  = 1'b1;
      winner = IW'(REQ_PLAY);
    end else if (pending[REQ_REC]) begin
      valid  = 1'b1;
      winner = IW'(REQ_REC);
    end else begin
      for (int k = 0; k < NBULK; k++) begin
        if (!valid && pending[bulk_index(int'(ptr), k, NREQ)]) begin
          valid  = 1'b1;
          winner = IW'(bulk_index(int'(ptr), k, NREQ));
        end
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//   Arbitrates NREQ audio requesters onto a single SDRAM bus block. One
//   command is in flight at a time: IDLE picks and latches a winner, BUSY
//   holds the command strobes until the bus block reports completion, GAP
//   spends one quiet cycle so the owner can drop its request.
//
//   Configuration
//     SDRAM_ARB_RR_EN  defined: bulk requesters (mix, pitch, loaddata) are
//                      served round-robin; undefined: fixed priority
//                      mix > pitch > loaddata.
//
//   Ports
//     i_clk, i_rst_n        clock, asynchronous active-low reset
//     req_read/req_write    per-requester level requests (write wins if both)
//     req_addr/req_writedata per-requester command fields
//     req_readdata          read data, valid for the owner on its finished pulse
//     req_finished          one-cycle completion pulse to the owner
//     sdram_read/_write     command strobes to the bus block
//     sdram_addr/_writedata command fields to the bus block
//     sdram_readdata        read data from the bus block
//     sdram_finished        one-cycle completion pulse from the bus block
//     grant                 one-hot current owner, zero when not in BUSY
//     busy                  high in BUSY and GAP
// ---------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int NREQ = sdram_arbiter_pkg::NREQ,
  parameter int AW   = sdram_arbiter_pkg::AW,
  parameter int DW   = sdram_arbiter_pkg::DW
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NREQ-1:0]          req_read,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ-1:0][AW-1:0]  req_addr,
  input  logic [NREQ-1:0][DW-1:0]  req_writedata,
  output logic [NREQ-1:0][DW-1:0]  req_readdata,
  output logic [NREQ-1:0]          req_finished,
  output logic                     sdram_read,
  output logic                     sdram_write,
  output logic [AW-1:0]            sdram_addr,
  output logic [DW-1:0]            sdram_writedata,
  input  logic [DW-1:0]            sdram_readdata,
  input  logic                     sdram_finished,
  output logic [NREQ-1:0]          grant,
  output logic                     busy
);
  import sdram_arbiter_pkg::*;

  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            rd_q,    rd_d;
  logic            wr_q,    wr_d;
  logic            busy_q,  busy_d;

  logic [NREQ-1:0] pending;
  logic            pick_valid;
  logic [IW-1:0]   pick_winner;
  logic [IW-1:0]   pick_ptr;

  assign pending = req_read | req_write;

  sdram_arb_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .pending (pending),
    .ptr     (pick_ptr),
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

`ifdef SDRAM_ARB_RR_EN
  // Round-robin pointer over the bulk slots; moves one past each bulk winner.
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  assign pick_ptr = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_IDLE && pick_valid && pick_winner >= IW'(REQ_MIX)) begin
      rr_ptr_d = (pick_winner == IW'(NREQ - 1)) ? IW'(REQ_MIX)
                                                 : pick_winner + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rr_ptr_q <= IW'(REQ_MIX);
    else          rr_ptr_q <= rr_ptr_d;
  end
`else
  assign pick_ptr = IW'(REQ_MIX);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d              = '0;
          grant_d[pick_winner] = 1'b1;
          addr_d               = req_addr[pick_winner];
          wdata_d              = req_writedata[pick_winner];
          // Read and write together on one requester is a write.
          wr_d                 = req_write[pick_winner];
          rd_d                 = ~req_write[pick_winner];
          busy_d               = 1'b1;
          state_d              = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // The command is latched, so a requester dropping its level here
        // does not abort it; only the bus block's completion ends BUSY.
        if (sdram_finished) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          grant_d = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values and the update order inside the block is
  // irrelevant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
    end
  end

  assign sdram_read      = rd_q;
  assign sdram_write     = wr_q;
  assign sdram_addr      = addr_q;
  assign sdram_writedata = wdata_q;
  assign grant           = grant_q;
  assign busy            = busy_q;

  // Completion is forwarded in the same cycle it arrives, and only to the
  // owner; stray completions outside BUSY never reach a requester.
  always_comb begin
    req_finished = '0;
    req_readdata = '0;
    if (state_q == ST_BUSY && sdram_finished) begin
      req_finished = grant_q;
      for (int i = 0; i < NREQ; i++) begin
        if (grant_q[i]) req_readdata[i] = sdram_readdata;
      end
    end
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 5, number of requester ports (0=play, 1=record, 2=mix, 3=pitch, 4=loaddata).
REQ-002 SHALL have parameter AW, default 23, SDRAM word-address width.
REQ-003 SHALL have parameter DW, default 32, SDRAM data width.
REQ-004 i_clk  in  1  sole clock; all state on rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_read  in  NREQ  per-requester read request, level, held until its finished pulse.
REQ-007 req_write  in  NREQ  per-requester write request, level, held until its finished pulse.
REQ-008 req_addr  in  NREQ x AW  per-requester address.
REQ-009 req_writedata  in  NREQ x DW  per-requester write data.
REQ-010 req_readdata  out  NREQ x DW  per-requester read data.
REQ-011 req_finished  out  NREQ  per-requester one-cycle completion pulse.
REQ-012 sdram_read / sdram_write  out  1 each  command strobes to the SDRAM bus block.
REQ-013 sdram_addr  out  AW; sdram_writedata  out  DW  command fields.
REQ-014 sdram_readdata  in  DW; sdram_finished  in  1  one-cycle completion pulse from the bus block.
REQ-015 grant  out  NREQ  one-hot current owner, zero when idle; busy  out  1.

Function
REQ-016 States: IDLE, BUSY, GAP.
REQ-017 IDLE: a requester is pending when req_read or req_write is set; if any is pending, latch the winner's index, addr, writedata and direction on this edge; go to BUSY.
REQ-018 Priority: play > record (real-time); below them, mix, pitch, loaddata are arbitrated per REQ-031/032.
REQ-019 Read and write both set on one requester: treated as write.
REQ-020 BUSY: sdram_read/sdram_write driven from latched direction, addr/writedata from latched registers, constant until sdram_finished; first strobe is on the cycle after the request is first seen in IDLE (latency 1).
REQ-021 On sdram_finished in BUSY: req_finished[owner] pulses that same cycle, req_readdata[owner] = sdram_readdata that cycle; strobes drop next cycle; go to GAP.
REQ-022 req_finished and req_readdata of non-owners SHALL be 0 at all times.
REQ-023 GAP: one cycle, no strobes, grant zero, lets the owner deassert its request; then IDLE.
REQ-024 Requester dropping its request during BUSY does not abort; the latched command completes and finished still pulses.
REQ-025 sdram_finished outside BUSY is ignored.
REQ-026 New requests arriving during BUSY/GAP wait; no request is lost while held.
REQ-027 busy = 1 in BUSY and GAP.

Reset
REQ-028 On i_rst_n low, asynchronously: state IDLE, all strobes, grant, busy, req_finished, req_readdata = 0; latched fields cleared.
REQ-029 Reset mid-BUSY abandons the command with no finished pulse.
REQ-030 Round-robin pointer resets to mix (index 2).

Configuration
REQ-031 With SDRAM_ARB_RR_EN defined: mix/pitch/loaddata round-robin; pointer advances to one past the winner after each bulk grant.
REQ-032 Without SDRAM_ARB_RR_EN: fixed priority mix > pitch > loaddata; no pointer register.

Structure
REQ-033 Shared package holds requester index constants (REQ_PLAY..REQ_LOAD), NREQ, AW, DW and the state enum.
REQ-034 One sub-module, sdram_arb_pick: combinational winner selection from pending vector and pointer.

Verification
REQ-035 Play read addr 0x000100 alone -> sdram_read high one cycle after request, addr 0x000100; finished with readdata 0xDEADBEEF -> req_finished[0] pulse, req_readdata[0]=0xDEADBEEF, others 0.
REQ-036 Play and loaddata requested same cycle -> play granted first; loaddata granted in IDLE after play's GAP.
REQ-037 Record write 0x12345678 to 0x000040, request dropped mid-BUSY -> sdram_write held with same data/addr until finished; req_finished[1] pulses.
REQ-038 RR_EN: mix, pitch, loaddata held continuously -> grant order mix, pitch, loaddata, mix; without macro -> mix on every grant.
REQ-039 Reset asserted in BUSY -> strobes, grant, busy 0 immediately; later sdram_finished produces no req_finished.
REQ-040 Stray sdram_finished in IDLE -> no req_finished pulse, state unchanged.
